// File: rtl/conv_host_sequencer.sv
// Host-side sequencer: streams filter/image words into shared memory, kicks the
// accelerator, waits for done (with timeout) and streams the result words back out.
module conv_host_sequencer #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 8,
  parameter int IN_WORDS  = 68,
  parameter int IN_BASE   = 0,
  parameter int RES_WORDS = 43,
  parameter int RES_BASE  = 128,
  parameter int TIMEOUT   = 65535
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              go,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mem_wr_en,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_adr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              acc_start,
  input  logic              acc_done,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              finished,
  output logic              timeout_err
);

  // Handshakes: a word moves on a stream only in a cycle where valid and ready
  // are both high at posedge; out_valid/out_data stay stable until that happens.

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_KICK, S_WAIT, S_READ, S_LATCH, S_SEND, S_FIN
  } state_t;

  localparam int WCNT_W = $clog2(IN_WORDS + 1);
  localparam int RCNT_W = $clog2(RES_WORDS + 1);
  localparam logic [ADDR_W-1:0] IN_BASE_A  = ADDR_W'(IN_BASE);
  localparam logic [ADDR_W-1:0] RES_BASE_A = ADDR_W'(RES_BASE);

  state_t              state, state_d;
  logic [WCNT_W-1:0]   wcnt;
  logic [RCNT_W-1:0]   rcnt;
  logic [15:0]         tcnt;
  logic [DATA_W-1:0]   out_q;
  logic                timeout_q;
  logic                last_in, last_res, tc_hit;

  assign last_in  = (wcnt == WCNT_W'(IN_WORDS - 1));
  assign last_res = (rcnt == RCNT_W'(RES_WORDS - 1));
  assign tc_hit   = (tcnt == 16'(TIMEOUT - 1));

  always_comb begin
    state_d = state;
    case (state)
      S_IDLE:  if (go) state_d = S_LOAD;
      S_LOAD:  if (in_valid && last_in) state_d = S_KICK;
      S_KICK:  state_d = S_WAIT;
      S_WAIT: begin
        if (acc_done)    state_d = S_READ;
        else if (tc_hit) state_d = S_FIN;
      end
      S_READ:  state_d = S_LATCH;
      S_LATCH: state_d = S_SEND;
      S_SEND:  if (out_ready) state_d = last_res ? S_FIN : S_READ;
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      wcnt      <= '0;
      rcnt      <= '0;
      tcnt      <= '0;
      out_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state <= state_d;
      case (state)
        S_IDLE: if (go) begin
          wcnt      <= '0;
          rcnt      <= '0;
          tcnt      <= '0;
          timeout_q <= 1'b0;
        end
        S_LOAD:  if (in_valid) wcnt <= wcnt + 1'b1;
        S_WAIT: if (!acc_done) begin
          if (tc_hit) timeout_q <= 1'b1;
          else        tcnt <= tcnt + 16'd1;
        end
        S_LATCH: out_q <= mem_rdata;
        S_SEND:  if (out_ready) rcnt <= rcnt + 1'b1;
        default: ;
      endcase
    end
  end

  // Memory strobes are decoded from state, so write and read can never overlap.
  always_comb begin
    in_ready  = 1'b0;
    mem_wr_en = 1'b0;
    mem_rd_en = 1'b0;
    mem_adr   = '0;
    mem_wdata = '0;
    acc_start = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    finished  = 1'b0;
    case (state)
      S_LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          mem_wr_en = 1'b1;
          mem_adr   = IN_BASE_A + ADDR_W'(wcnt);
          mem_wdata = in_data;
        end
      end
      S_KICK: acc_start = 1'b1;
      S_READ: begin
        mem_rd_en = 1'b1;
        mem_adr   = RES_BASE_A + ADDR_W'(rcnt);
      end
      S_SEND: begin
        out_valid = 1'b1;
        out_last  = last_res;
      end
      S_FIN:  finished = 1'b1;
      default: ;
    endcase
  end

  assign out_data    = out_q;
  assign busy        = (state != S_IDLE);
  assign timeout_err = timeout_q;

endmodule

// File: tb/tb_conv_host_sequencer.sv
// Directed bench for conv_host_sequencer: memory model, write scoreboard,
// result checks with backpressure, timeout and mid-operation reset.
module tb_conv_host_sequencer;

  localparam int TMO = 32;

  logic       clk = 1'b0;
  logic       rst, go, in_valid, out_ready, acc_done;
  logic [7:0] in_data, mem_rdata;
  logic       in_ready, mem_wr_en, mem_rd_en, acc_start;
  logic [7:0] mem_adr, mem_wdata, out_data;
  logic       out_valid, out_last, busy, finished, timeout_err;

  int n_tests = 0;
  int n_fail  = 0;
  int start_cnt = 0, rd_cnt = 0, wr_cnt = 0;
  logic [15:0] exp_q[$];
  logic [7:0]  mem[256];

  conv_host_sequencer #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .go(go), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .mem_wr_en(mem_wr_en), .mem_rd_en(mem_rd_en),
    .mem_adr(mem_adr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .acc_start(acc_start), .acc_done(acc_done), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .busy(busy), .finished(finished), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Memory model: synchronous write, one-cycle read latency.
  always @(posedge clk) begin
    if (mem_wr_en) mem[mem_adr] <= mem_wdata;
    if (mem_rd_en) mem_rdata <= mem[mem_adr];
    if (acc_start) start_cnt++;
    if (mem_rd_en) rd_cnt++;
    if (mem_wr_en) wr_cnt++;
  end

  // Write scoreboard plus strobe exclusivity.
  always @(negedge clk) begin
    check("wr_rd_excl", {31'd0, mem_wr_en & mem_rd_en}, 32'd0);
    if (mem_wr_en) begin
      if (exp_q.size() == 0) check("wr_extra", 32'd1, 32'd0);
      else check("wr_adr_data", {16'd0, mem_adr, mem_wdata}, {16'd0, exp_q.pop_front()});
    end
  end

  task automatic check_zero(input string tag);
    check({tag, "_in_ready"}, {31'd0, in_ready}, 0);
    check({tag, "_wr_en"}, {31'd0, mem_wr_en}, 0);
    check({tag, "_rd_en"}, {31'd0, mem_rd_en}, 0);
    check({tag, "_adr"}, {24'd0, mem_adr}, 0);
    check({tag, "_wdata"}, {24'd0, mem_wdata}, 0);
    check({tag, "_start"}, {31'd0, acc_start}, 0);
    check({tag, "_out_data"}, {24'd0, out_data}, 0);
    check({tag, "_out_valid"}, {31'd0, out_valid}, 0);
    check({tag, "_out_last"}, {31'd0, out_last}, 0);
    check({tag, "_busy"}, {31'd0, busy}, 0);
    check({tag, "_finished"}, {31'd0, finished}, 0);
    check({tag, "_timeout"}, {31'd0, timeout_err}, 0);
  endtask

  task automatic pulse_go();
    go = 1'b1;
    @(posedge clk); #1;
    go = 1'b0;
    @(negedge clk);
    check("go_busy", {31'd0, busy}, 1);
    check("go_in_ready", {31'd0, in_ready}, 1);
    check("go_clears_timeout", {31'd0, timeout_err}, 0);
    @(posedge clk); #1;
  endtask

  task automatic load_words(input int n, input bit stall, input logic [7:0] seed);
    for (int i = 0; i < n; i++) begin
      if (stall) begin
        in_valid = 1'b0;
        in_data  = 8'h55;
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_data  = seed + 8'(i);
      exp_q.push_back({8'(i), seed + 8'(i)});
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  // Called right after the last load posedge; leaves us in WAIT cycle 1 at posedge+1.
  task automatic check_kick(input int start0, input int wr0);
    @(negedge clk);
    check("kick_start", {31'd0, acc_start}, 1);
    check("kick_wr_count", wr_cnt - wr0, 68);
    check("kick_exp_q_empty", exp_q.size(), 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("kick_one_cycle", {31'd0, acc_start}, 0);
    check("kick_start_count", start_cnt - start0, 1);
    check("wait_busy", {31'd0, busy}, 1);
  endtask

  task automatic unload(input bit bp);
    int  rd0, rdh;
    bit  got;
    rd0 = rd_cnt;
    repeat (18) @(posedge clk);
    #1 acc_done = 1'b1;
    @(posedge clk); #1;
    acc_done = 1'b0;
    for (int k = 0; k < 43; k++) begin
      out_ready = (bp && k == 7) ? 1'b0 : 1'b1;
      got = 1'b0;
      for (int w = 0; w < 8; w++) begin
        @(negedge clk);
        if (out_valid) begin
          got = 1'b1;
          break;
        end
      end
      check("out_wait", {31'd0, got}, 1);
      check("out_data", {24'd0, out_data}, 32'hA0 + k);
      check("out_last", {31'd0, out_last}, (k == 42) ? 1 : 0);
      if (bp && k == 7) begin
        rdh = rd_cnt;
        repeat (5) begin
          @(posedge clk); #1;
          @(negedge clk);
          check("bp_valid", {31'd0, out_valid}, 1);
          check("bp_data", {24'd0, out_data}, 32'hA7);
          check("bp_no_read", rd_cnt - rdh, 0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("fin_pulse", {31'd0, finished}, 1);
    check("fin_out_valid", {31'd0, out_valid}, 0);
    check("read_count", rd_cnt - rd0, 43);
    @(posedge clk); #1;
    @(negedge clk);
    check("fin_one_cycle", {31'd0, finished}, 0);
    check("fin_idle", {31'd0, busy}, 0);
  endtask

  initial begin
    int s0, w0, r0;
    bit got;
    for (int i = 0; i < 256; i++) mem[i] = (i >= 128) ? 8'(8'hA0 + (i - 128)) : 8'h00;
    rst = 1'b1; go = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    out_ready = 1'b0; acc_done = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_zero("reset");
    @(posedge clk); #1;

    // Basic run with backpressure on word 7.
    s0 = start_cnt; w0 = wr_cnt;
    pulse_go();
    load_words(68, 1'b0, 8'h00);
    check_kick(s0, w0);
    unload(1'b1);

    // Stalled input, unload without backpressure.
    @(posedge clk); #1;
    s0 = start_cnt; w0 = wr_cnt;
    pulse_go();
    load_words(68, 1'b1, 8'h80);
    check_kick(s0, w0);
    unload(1'b0);

    // Timeout: done never arrives.
    @(posedge clk); #1;
    s0 = start_cnt; w0 = wr_cnt; r0 = rd_cnt;
    pulse_go();
    load_words(68, 1'b0, 8'h20);
    check_kick(s0, w0);
    repeat (TMO - 1) @(posedge clk);
    @(negedge clk);
    check("tmo_not_yet", {31'd0, timeout_err}, 0);
    check("tmo_still_busy", {31'd0, busy}, 1);
    @(negedge clk);
    check("tmo_err", {31'd0, timeout_err}, 1);
    check("tmo_fin", {31'd0, finished}, 1);
    @(negedge clk);
    check("tmo_idle", {31'd0, busy}, 0);
    check("tmo_sticky", {31'd0, timeout_err}, 1);
    check("tmo_no_reads", rd_cnt - r0, 0);
    @(posedge clk); #1;
    pulse_go();

    // Reset during LOAD at wcnt=30.
    load_words(30, 1'b0, 8'h10);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_zero("rst_load");
    exp_q.delete();
    @(posedge clk); #1;

    // Restart from address 0, then reset during SEND.
    s0 = start_cnt; w0 = wr_cnt;
    pulse_go();
    load_words(68, 1'b0, 8'h40);
    check_kick(s0, w0);
    out_ready = 1'b0;
    @(posedge clk); #1 acc_done = 1'b1;
    @(posedge clk); #1 acc_done = 1'b0;
    got = 1'b0;
    for (int w = 0; w < 8; w++) begin
      @(negedge clk);
      if (out_valid) begin
        got = 1'b1;
        break;
      end
    end
    check("send_reached", {31'd0, got}, 1);
    check("send_first", {24'd0, out_data}, 32'hA0);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check_zero("rst_send");
    repeat (3) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

endmodule
